stream_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit stb/ack output stream (e.g. `output_rs232_tx`) between up to N producer processes in `user_design`. It grants one requester at a time, buffers one word, and optionally locks the grant until an end-of-packet word so that text lines from different processes do not interleave. A stalled locked requester is released by a timeout, which also raises a sticky `exception` that is ORed into the top-level exception.

---
 rtl/stream_pkg.sv | 20 ++
 rtl/stream_arbiter_if.sv | 33 +++
 rtl/stream_arbiter_rr_pick.sv | 34 +++
 rtl/stream_arbiter.sv | 148 ++++++++++++++
 tb/tb_stream_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_pkg
// Brief   : Shared types and constants for the stream arbiter slice.
// Revision: 1.0
// ============================================================================
package stream_pkg;

  localparam int                      STREAM_WIDTH = 32;
  localparam logic [STREAM_WIDTH-1:0] EOP_DEFAULT  = 32'h0000_000A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    SEND   = 2'd2,
    HOLD   = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : stream_arbiter_if
// Brief   : N requester streams in, one merged stb/ack stream out.
// Revision: 1.0
// ============================================================================
interface stream_arbiter_if #(
  parameter int N_INPUTS = 4,
  parameter int WIDTH    = stream_pkg::STREAM_WIDTH
);

  logic [N_INPUTS*WIDTH-1:0] input_in;
  logic [N_INPUTS-1:0]       input_in_stb;
  logic [N_INPUTS-1:0]       input_in_ack;
  logic [WIDTH-1:0]          output_out;
  logic                      output_out_stb;
  logic                      output_out_ack;
  logic [N_INPUTS-1:0]       grant;
  logic                      exception;

  // The arbiter itself sits on the slave side.
  modport slave (
    input  input_in, input_in_stb, output_out_ack,
    output input_in_ack, output_out, output_out_stb, grant, exception
  );

  modport master (
    output input_in, input_in_stb, output_out_ack,
    input  input_in_ack, output_out, output_out_stb, grant, exception
  );

endinterface
`default_nettype wire

// File: rtl/stream_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Rotating priority encoder; first set request at or after ptr.
// Revision: 1.0
// ============================================================================
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 valid
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : stream_arbiter
// Brief   : Round-robin stream arbiter with one-word buffer and packet lock.
// Revision: 1.0
// ============================================================================
module stream_arbiter
  import stream_pkg::*;
#(
  parameter int               N_INPUTS  = 4,
  parameter int               WIDTH     = STREAM_WIDTH,
  parameter int               LOCK      = 1,
  parameter logic [WIDTH-1:0] EOP_VALUE = WIDTH'(EOP_DEFAULT),
  parameter int               TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  stream_arbiter_if.slave  bus
);

  localparam int            PW         = $clog2(N_INPUTS);
  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] LAST_IDX   = PW'(N_INPUTS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       next_ptr, pick_idx;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_INPUTS-1:0] grant_q, grant_d;
  logic [N_INPUTS-1:0] ack_q, ack_d;
  logic [N_INPUTS-1:0] pick_gnt;
  logic                pick_valid;
  logic                stb_q, stb_d;
  logic                exc_q, exc_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    in_words [N_INPUTS];

  generate
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
      assign in_words[i] = bus.input_in[i*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(.N(N_INPUTS)) u_pick (
    .req   (bus.input_in_stb),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  // Releasing always moves priority past the owner so it cannot be re-granted first.
  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    timer_d = timer_q;
    grant_d = grant_q;
    ack_d   = '0;
    stb_d   = stb_q;
    data_d  = data_q;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          ack_d   = pick_gnt;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        data_d  = in_words[owner_q];
        stb_d   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (bus.output_out_ack) begin
          stb_d = 1'b0;
          if (LOCK == 0 || data_q == EOP_VALUE) begin
            state_d = IDLE;
            ptr_d   = next_ptr;
            grant_d = '0;
          end else begin
            state_d = HOLD;
            timer_d = '0;
          end
        end
      end
      HOLD: begin
        if (bus.input_in_stb[owner_q]) begin
          ack_d   = grant_q;
          state_d = ACCEPT;
        end else if (timer_q == TIMER_LAST) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
          grant_d = '0;
          timer_d = '0;
          exc_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      timer_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.input_in_ack   = ack_q;
  assign bus.output_out     = data_q;
  assign bus.output_out_stb = stb_q;
  assign bus.grant          = grant_q;
  assign bus.exception      = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_arbiter
// Brief   : Scoreboard bench for stream_arbiter (locked and unlocked builds).
// Revision: 1.0
// ============================================================================
module tb_stream_arbiter;

  localparam int          N   = 4;
  localparam int          W   = 32;
  localparam int          TMO = 8;
  localparam logic [31:0] EOP = 32'h0000_000A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_arbiter_if #(.N_INPUTS(N), .WIDTH(W)) bus_l ();
  stream_arbiter_if #(.N_INPUTS(N), .WIDTH(W)) bus_u ();

  stream_arbiter #(.N_INPUTS(N), .WIDTH(W), .LOCK(1), .EOP_VALUE(EOP), .TIMEOUT(TMO))
    dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  stream_arbiter #(.N_INPUTS(N), .WIDTH(W), .LOCK(0), .EOP_VALUE(EOP), .TIMEOUT(TMO))
    dut_u (.clk(clk), .rst(rst), .bus(bus_u));

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_l [$];
  logic [31:0] pq [N][$];
  logic [31:0] pk [N][$];
  logic [N-1:0] hs;
  bit          ack_rand  = 1'b0;
  bit          ack_force = 1'b1;
  int          m_ptr     = 0;
  logic [31:0] fw [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic bit pq_busy();
    bit b = 1'b0;
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input string name, input int maxc);
    int c = 0;
    while ((exp_l.size() != 0 || pq_busy()) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(c < maxc), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Reference: every requester holds stb continuously, so whole packets are
  // served round-robin from the pointer, skipping requesters with nothing left.
  task automatic model_issue();
    bit          done = 1'b0;
    bit          found;
    int          i;
    logic [31:0] w;
    while (!done) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && pk[i].size() != 0) begin
          found = 1'b1;
          w = 32'h0;
          while (w != EOP && pk[i].size() != 0) begin
            w = pk[i].pop_front();
            exp_l.push_back(w);
            pq[i].push_back(w);
          end
          m_ptr = (i + 1) % N;
        end
      end
      if (!found) done = 1'b1;
    end
  endtask

  // Producers for the locked DUT: present queue heads, pop on handshake.
  initial begin
    bus_l.input_in     = '0;
    bus_l.input_in_stb = '0;
    forever begin
      @(negedge clk);
      hs = bus_l.input_in_stb & bus_l.input_in_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        if (pq[i].size() != 0) begin
          bus_l.input_in[i*W +: W] = pq[i][0];
          bus_l.input_in_stb[i]    = 1'b1;
        end else begin
          bus_l.input_in_stb[i]    = 1'b0;
        end
      end
    end
  end

  initial begin
    bus_l.output_out_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_l.output_out_ack = ack_rand ? ($urandom_range(0, 3) != 0) : ack_force;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_l.output_out_stb && bus_l.output_out_ack) begin
      if (exp_l.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got %h, expected no word", bus_l.output_out);
      end else begin
        check("sb_word", bus_l.output_out, exp_l.pop_front());
      end
    end
  end

  initial begin
    int          c;
    int          got;
    int          bad;
    int          npk;
    int          len;
    logic [31:0] w;
    logic [N-1:0] prev;

    bus_u.input_in       = '0;
    bus_u.input_in_stb   = '0;
    bus_u.output_out_ack = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_grant",     32'(bus_l.grant), 32'd0);
    check("rst_in_ack",    32'(bus_l.input_in_ack), 32'd0);
    check("rst_out_stb",   32'(bus_l.output_out_stb), 32'd0);
    check("rst_out",       bus_l.output_out, 32'd0);
    check("rst_exception", 32'(bus_l.exception), 32'd0);
    check("rst_grant_u",   32'(bus_u.grant), 32'd0);
    rst = 1'b0;

    // Fairness on the unlocked build: all requesters hold stb.
    @(negedge clk);
    for (int i = 0; i < N; i++) bus_u.input_in[i*W +: W] = 32'(32'hA0 + i);
    bus_u.input_in_stb = '1;
    got = 0; bad = 0; prev = '0; c = 0;
    while (got < 5 && c < 40) begin
      @(negedge clk);
      c++;
      if ((bus_u.input_in_ack & prev) != '0 || $countones(bus_u.input_in_ack) > 1) bad++;
      prev = bus_u.input_in_ack;
      if (bus_u.output_out_stb && bus_u.output_out_ack) begin
        fw[got] = bus_u.output_out;
        got++;
      end
    end
    bus_u.input_in_stb = '0;
    check("fair_count", 32'(got), 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("fair_order%0d", k), fw[k], 32'(32'hA0 + (k % N)));
    check("fair_ack_pulse", 32'(bad), 32'd0);

    // Single request on requester 2: latency and grant.
    @(negedge clk);
    pq[2].push_back(32'h41); pq[2].push_back(EOP);
    exp_l.push_back(32'h41); exp_l.push_back(EOP);
    c = 0;
    while (!bus_l.input_in_stb[2] && c < 10) begin @(negedge clk); c++; end
    check("single_ack_t0", 32'(bus_l.input_in_ack), 32'd0);
    @(negedge clk);
    check("single_ack_t1",   32'(bus_l.input_in_ack), 32'b0100);
    check("single_grant_t1", 32'(bus_l.grant), 32'b0100);
    @(negedge clk);
    check("single_stb_t2",   32'(bus_l.output_out_stb), 32'd1);
    check("single_data_t2",  bus_l.output_out, 32'h41);
    check("single_ack_t2",   32'(bus_l.input_in_ack), 32'd0);
    check("single_grant_t2", 32'(bus_l.grant), 32'b0100);
    wait_drain("single_drain", 100);

    // Locking: requester 3 must wait for requester 1's EOP.
    pq[1].push_back(32'h48); pq[1].push_back(32'h49); pq[1].push_back(EOP);
    exp_l.push_back(32'h48); exp_l.push_back(32'h49); exp_l.push_back(EOP);
    exp_l.push_back(32'h5A); exp_l.push_back(EOP);
    c = 0;
    while (!bus_l.input_in_ack[1] && c < 20) begin @(negedge clk); c++; end
    check("lock_first_ack", 32'(c < 20), 32'd1);
    pq[3].push_back(32'h5A); pq[3].push_back(EOP);
    wait_drain("lock_drain", 200);

    // Timeout: requester 0 abandons its packet while requester 1 waits.
    pq[0].push_back(32'h48);
    exp_l.push_back(32'h48); exp_l.push_back(32'h31); exp_l.push_back(EOP);
    c = 0;
    while (!bus_l.input_in_ack[0] && c < 20) begin @(negedge clk); c++; end
    pq[1].push_back(32'h31); pq[1].push_back(EOP);
    c = 0;
    while (!(bus_l.output_out_stb && bus_l.output_out_ack) && c < 20) begin @(negedge clk); c++; end
    check("tmo_exc_before", 32'(bus_l.exception), 32'd0);
    c = 0;
    do begin @(negedge clk); c++; end while (!bus_l.input_in_ack[1] && c < 40);
    check("tmo_release_cycles", 32'(c), 32'(TMO + 2));
    check("tmo_exc_set", 32'(bus_l.exception), 32'd1);
    wait_drain("tmo_drain", 200);

    // Backpressure: 20 stalled SEND cycles.
    ack_force = 1'b0;
    pq[2].push_back(32'h77); pq[2].push_back(EOP);
    exp_l.push_back(32'h77); exp_l.push_back(EOP);
    c = 0;
    while (!bus_l.output_out_stb && c < 20) begin @(negedge clk); c++; end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus_l.output_out_stb || bus_l.output_out != 32'h77 || bus_l.input_in_ack != '0) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    ack_force = 1'b1;
    @(negedge clk);
    check("bp_handshake", 32'(bus_l.output_out_stb && bus_l.output_out_ack), 32'd1);
    @(negedge clk);
    check("bp_done", 32'(bus_l.output_out_stb), 32'd0);
    wait_drain("bp_drain", 200);
    check("exc_sticky", 32'(bus_l.exception), 32'd1);

    // Reset while a word is buffered in SEND.
    ack_force = 1'b0;
    pq[1].push_back(32'h55); pq[1].push_back(EOP);
    exp_l.push_back(32'h55);
    c = 0;
    while (!bus_l.output_out_stb && c < 20) begin @(negedge clk); c++; end
    rst = 1'b1;
    pq[1].delete();
    exp_l.delete();
    @(negedge clk);
    check("rstmid_out_stb", 32'(bus_l.output_out_stb), 32'd0);
    check("rstmid_grant",   32'(bus_l.grant), 32'd0);
    check("rstmid_exc",     32'(bus_l.exception), 32'd0);
    check("rstmid_out",     bus_l.output_out, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    ack_force = 1'b1;
    ack_rand  = 1'b1;
    m_ptr     = 0;
    pk[3].push_back(32'h33); pk[3].push_back(EOP);
    pk[0].push_back(32'h30); pk[0].push_back(EOP);
    model_issue();
    wait_drain("rstmid_drain", 300);

    // Randomized rounds against the packet-level model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len - 1; j++) begin
            w = $urandom();
            if (w == EOP) w = 32'h1234_5678;
            pk[i].push_back(w);
          end
          pk[i].push_back(EOP);
        end
      end
      model_issue();
      wait_drain($sformatf("rand_drain%0d", r), 3000);
    end
    check("rand_no_exc", 32'(bus_l.exception), 32'd0);
    check("sb_empty", 32'(exp_l.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
